// File: rtl/power_off_ctr.sv
// OV5640 power-down sequencer: waits for SCCB idle and a frame boundary,
// then drops RSTB, raises PWDN and reports the sensor as off.
module power_off_ctr #(
  parameter int Delay_IicTo    = 240000,
  parameter int Delay_FrameTo  = 2400000,
  parameter int Delay_RstHold  = 24000,
  parameter int Delay_PwdnHold = 24000
) (
  input  logic clk,
  input  logic rst,
  input  logic power_on_vd,
  input  logic power_off_req,
  input  logic iic_busy,
  input  logic cam_vsync,
  output logic camera_rstn_en,
  output logic camera_pwnd_force,
  output logic off_busy,
  output logic power_off_done,
  output logic iic_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACTIVE,
    S_WAIT_IIC,
    S_WAIT_VS,
    S_RST_LOW,
    S_PWDN_HIGH,
    S_OFF
  } state_t;

  // A hold of N exits when the timer reaches N-1; N=0 is treated as N=1.
  localparam logic [21:0] LIM_IIC   = (Delay_IicTo    <= 1) ? 22'd0 : 22'(Delay_IicTo - 1);
  localparam logic [21:0] LIM_FRAME = (Delay_FrameTo  <= 1) ? 22'd0 : 22'(Delay_FrameTo - 1);
  localparam logic [21:0] LIM_RST   = (Delay_RstHold  <= 1) ? 22'd0 : 22'(Delay_RstHold - 1);
  localparam logic [21:0] LIM_PWDN  = (Delay_PwdnHold <= 1) ? 22'd0 : 22'(Delay_PwdnHold - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [21:0] r_timer;
  logic        r_req_l;
  logic        r_vs_s1;
  logic        r_vs_s2;
  logic        r_vs_prev;
  logic        r_vs_rise;
  logic        r_rstn_en;
  logic        r_pwnd_force;
  logic        r_off_busy;
  logic        r_done;
  logic        r_iic_to;
  logic        w_to_set;
  logic        w_timed;
  logic        w_rstn_en_nxt;
  logic        w_pwnd_force_nxt;
  logic        w_off_busy_nxt;
  logic        w_done_nxt;

  // VSYNC is asynchronous: two flops to synchronise, then a registered edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vs_s1   <= 1'b0;
      r_vs_s2   <= 1'b0;
      r_vs_prev <= 1'b0;
      r_vs_rise <= 1'b0;
    end else begin
      r_vs_s1   <= cam_vsync;
      r_vs_s2   <= r_vs_s1;
      r_vs_prev <= r_vs_s2;
      r_vs_rise <= r_vs_s2 & ~r_vs_prev;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign w_timed = (r_state == S_WAIT_IIC) || (r_state == S_WAIT_VS) ||
                   (r_state == S_RST_LOW)  || (r_state == S_PWDN_HIGH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_timer <= 22'd0;
    end else if (w_state_nxt != r_state) begin
      r_timer <= 22'd0;
    end else if (w_timed) begin
      r_timer <= r_timer + 22'd1;
    end
  end

  // A request arriving before power-on completes is remembered for ACTIVE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req_l <= 1'b0;
    end else if (w_state_nxt == S_WAIT_IIC && r_state != S_WAIT_IIC) begin
      r_req_l <= 1'b0;
    end else if (power_off_req && (r_state == S_IDLE || r_state == S_ACTIVE)) begin
      r_req_l <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_to_set    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (power_on_vd) w_state_nxt = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (!power_on_vd)  w_state_nxt = S_IDLE;
        else if (r_req_l)  w_state_nxt = S_WAIT_IIC;
      end
      S_WAIT_IIC: begin
        if (!iic_busy) begin
          w_state_nxt = S_WAIT_VS;
        end else if (r_timer == LIM_IIC) begin
          w_state_nxt = S_WAIT_VS;
          w_to_set    = 1'b1;
        end
      end
      S_WAIT_VS: begin
        if (r_vs_rise || r_timer == LIM_FRAME) w_state_nxt = S_RST_LOW;
      end
      S_RST_LOW: begin
        if (r_timer == LIM_RST) w_state_nxt = S_PWDN_HIGH;
      end
      S_PWDN_HIGH: begin
        if (r_timer == LIM_PWDN) w_state_nxt = S_OFF;
      end
      S_OFF: begin
        w_state_nxt = S_OFF;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on state entry.
  always_comb begin
    w_rstn_en_nxt    = 1'b1;
    w_pwnd_force_nxt = 1'b0;
    w_off_busy_nxt   = 1'b0;
    w_done_nxt       = 1'b0;
    case (w_state_nxt)
      S_WAIT_IIC, S_WAIT_VS: begin
        w_off_busy_nxt = 1'b1;
      end
      S_RST_LOW: begin
        w_off_busy_nxt = 1'b1;
        w_rstn_en_nxt  = 1'b0;
      end
      S_PWDN_HIGH: begin
        w_off_busy_nxt   = 1'b1;
        w_rstn_en_nxt    = 1'b0;
        w_pwnd_force_nxt = 1'b1;
      end
      S_OFF: begin
        w_rstn_en_nxt    = 1'b0;
        w_pwnd_force_nxt = 1'b1;
        w_done_nxt       = 1'b1;
      end
      default: begin
        w_rstn_en_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rstn_en    <= 1'b1;
      r_pwnd_force <= 1'b0;
      r_off_busy   <= 1'b0;
      r_done       <= 1'b0;
      r_iic_to     <= 1'b0;
    end else begin
      r_rstn_en    <= w_rstn_en_nxt;
      r_pwnd_force <= w_pwnd_force_nxt;
      r_off_busy   <= w_off_busy_nxt;
      r_done       <= w_done_nxt;
      r_iic_to     <= r_iic_to | w_to_set;
    end
  end

  assign camera_rstn_en    = r_rstn_en;
  assign camera_pwnd_force = r_pwnd_force;
  assign off_busy          = r_off_busy;
  assign power_off_done    = r_done;
  assign iic_timeout       = r_iic_to;

endmodule

// File: tb/tb_power_off_ctr.sv
// Bench for power_off_ctr: phase-level reference model checked every cycle,
// plus hand-computed cycle-distance expectations for each scenario.
module tb_power_off_ctr;

  localparam int IicTo    = 8;
  localparam int FrameTo  = 16;
  localparam int RstHold  = 10;
  localparam int PwdnHold = 6;

  localparam int PhIdle     = 0;
  localparam int PhActive   = 1;
  localparam int PhWaitIic  = 2;
  localparam int PhWaitVs   = 3;
  localparam int PhRstLow   = 4;
  localparam int PhPwdnHigh = 5;
  localparam int PhOff      = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic power_on_vd = 1'b0;
  logic power_off_req = 1'b0;
  logic iic_busy = 1'b0;
  logic cam_vsync = 1'b0;
  logic camera_rstn_en;
  logic camera_pwnd_force;
  logic off_busy;
  logic power_off_done;
  logic iic_timeout;

  int nCompared = 0;
  int nMismatched = 0;
  int cycle = 0;

  int mPhase;
  int mLeft;
  logic mPend;
  logic mPendNext;
  logic mTimeout;
  logic mRise;
  logic [4:0] mHist;

  power_off_ctr #(
    .Delay_IicTo   (IicTo),
    .Delay_FrameTo (FrameTo),
    .Delay_RstHold (RstHold),
    .Delay_PwdnHold(PwdnHold)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .power_on_vd      (power_on_vd),
    .power_off_req    (power_off_req),
    .iic_busy         (iic_busy),
    .cam_vsync        (cam_vsync),
    .camera_rstn_en   (camera_rstn_en),
    .camera_pwnd_force(camera_pwnd_force),
    .off_busy         (off_busy),
    .power_off_done   (power_off_done),
    .iic_timeout      (iic_timeout)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  function automatic int holdOf(input int n);
    return (n < 1) ? 1 : n;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cycle, act, exp);
    end
  endtask

  // Reference model: each timed phase lasts a fixed number of cycles counted
  // down from its hold; the DUT sees a VSYNC rise three samples after it lands.
  task automatic modelStep();
    if (!rst) begin
      mPhase   = PhIdle;
      mLeft    = 0;
      mPend    = 1'b0;
      mTimeout = 1'b0;
      mHist    = '0;
    end else begin
      mHist     = {mHist[3:0], cam_vsync};
      mRise     = mHist[3] & ~mHist[4];
      mPendNext = mPend | (power_off_req & (mPhase == PhIdle || mPhase == PhActive));
      case (mPhase)
        PhIdle: if (power_on_vd) mPhase = PhActive;
        PhActive: begin
          if (!power_on_vd) mPhase = PhIdle;
          else if (mPend) begin
            mPhase    = PhWaitIic;
            mLeft     = holdOf(IicTo);
            mPendNext = 1'b0;
          end
        end
        PhWaitIic: begin
          mLeft--;
          if (!iic_busy || mLeft == 0) begin
            if (iic_busy) mTimeout = 1'b1;
            mPhase = PhWaitVs;
            mLeft  = holdOf(FrameTo);
          end
        end
        PhWaitVs: begin
          mLeft--;
          if (mRise || mLeft == 0) begin
            mPhase = PhRstLow;
            mLeft  = holdOf(RstHold);
          end
        end
        PhRstLow: begin
          mLeft--;
          if (mLeft == 0) begin
            mPhase = PhPwdnHigh;
            mLeft  = holdOf(PwdnHold);
          end
        end
        PhPwdnHigh: begin
          mLeft--;
          if (mLeft == 0) mPhase = PhOff;
        end
        default: ;
      endcase
      mPend = mPendNext;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst);
    modelStep();
  end

  initial forever begin
    @(negedge clk);
    if (rst === 1'b1) begin
      checkOutput("model.rstnEn", camera_rstn_en,
                  (mPhase == PhRstLow || mPhase == PhPwdnHigh || mPhase == PhOff) ? 0 : 1);
      checkOutput("model.pwndForce", camera_pwnd_force,
                  (mPhase == PhPwdnHigh || mPhase == PhOff) ? 1 : 0);
      checkOutput("model.offBusy", off_busy,
                  (mPhase >= PhWaitIic && mPhase <= PhPwdnHigh) ? 1 : 0);
      checkOutput("model.done", power_off_done, (mPhase == PhOff) ? 1 : 0);
      checkOutput("model.iicTimeout", iic_timeout, mTimeout);
    end
  end

  function automatic logic sigOf(input int sel);
    case (sel)
      0:       return camera_rstn_en;
      1:       return camera_pwnd_force;
      2:       return off_busy;
      3:       return power_off_done;
      default: return iic_timeout;
    endcase
  endfunction

  task automatic waitFor(input string name, input int sel, input logic val,
                         input int maxCyc, output int at);
    int n;
    n  = 0;
    at = -1;
    while (at < 0 && n < maxCyc) begin
      @(negedge clk);
      if (sigOf(sel) === val) at = cycle;
      n++;
    end
    if (at < 0) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL %s timeout: signal never reached %0b within %0d cycles", name, val, maxCyc);
      at = cycle;
    end
  endtask

  task automatic applyStimulus(input logic req, input logic busy, input logic vs,
                               input logic pov, input int cycles);
    power_off_req = req;
    iic_busy      = busy;
    cam_vsync     = vs;
    power_on_vd   = pov;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 2);
    checkOutput("resetState",
                {camera_rstn_en, camera_pwnd_force, off_busy, power_off_done, iic_timeout},
                5'b10000);
    rst = 1'b1;
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int tEdge, tR, tP, tD, tB, tT, tV;

    // Normal sequence with a frame edge.
    applyReset();
    applyStimulus(0, 0, 0, 1, 3);
    applyStimulus(1, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 1, 4);
    applyStimulus(0, 0, 1, 1, 0);
    tEdge = cycle;
    waitFor("t1.rstnFall", 0, 1'b0, 40, tR);
    checkOutput("t1.vsyncToRstn", tR - tEdge, 4);
    waitFor("t1.pwndRise", 1, 1'b1, 40, tP);
    checkOutput("t1.rstHold", tP - tR, RstHold);
    waitFor("t1.doneRise", 3, 1'b1, 40, tD);
    checkOutput("t1.pwdnHold", tD - tP, PwdnHold);
    checkOutput("t1.noTimeout", iic_timeout, 0);

    // IIC stays busy: timeout after exactly IicTo cycles, then frame timeout.
    applyReset();
    applyStimulus(0, 1, 0, 1, 3);
    applyStimulus(1, 1, 0, 1, 1);
    applyStimulus(0, 1, 0, 1, 0);
    waitFor("t2.busyRise", 2, 1'b1, 20, tB);
    waitFor("t2.timeoutRise", 4, 1'b1, 40, tT);
    checkOutput("t2.iicWaitLen", tT - tB, IicTo);
    waitFor("t3.rstnFall", 0, 1'b0, 40, tR);
    checkOutput("t3.frameTimeout", tR - tT, FrameTo);
    waitFor("t2.doneRise", 3, 1'b1, 40, tD);
    checkOutput("t2.timeoutSticky", iic_timeout, 1);

    // IIC goes idle exactly on the timeout cycle: no timeout flag.
    applyReset();
    checkOutput("t2b.timeoutCleared", iic_timeout, 0);
    applyStimulus(0, 1, 0, 1, 3);
    applyStimulus(1, 1, 0, 1, 1);
    applyStimulus(0, 1, 0, 1, 0);
    waitFor("t2b.busyRise", 2, 1'b1, 20, tB);
    applyStimulus(0, 1, 0, 1, IicTo - 1);
    applyStimulus(0, 0, 0, 1, 0);
    waitFor("t2b.rstnFall", 0, 1'b0, 60, tR);
    checkOutput("t2b.entryToRstn", tR - tB, IicTo + FrameTo);
    checkOutput("t2b.noTimeout", iic_timeout, 0);
    waitFor("t2b.doneRise", 3, 1'b1, 40, tD);

    // Request while not powered is held until ACTIVE; power drop later ignored.
    applyReset();
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 20);
    checkOutput("t4.idleNoBusy", off_busy, 0);
    applyStimulus(0, 0, 0, 1, 0);
    tV = cycle;
    waitFor("t4.busyRise", 2, 1'b1, 20, tB);
    checkOutput("t4.povToBusy", tB - tV, 2);
    waitFor("t4.rstnFall", 0, 1'b0, 60, tR);
    applyStimulus(0, 0, 0, 0, 0);
    waitFor("t4.pwndRise", 1, 1'b1, 40, tP);
    checkOutput("t4.rstHold", tP - tR, RstHold);
    waitFor("t4.doneRise", 3, 1'b1, 40, tD);
    checkOutput("t4.pwdnHold", tD - tP, PwdnHold);

    // Asynchronous reset during PWDN_HIGH releases both forces immediately.
    applyReset();
    applyStimulus(0, 0, 0, 1, 3);
    applyStimulus(1, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 1, 0);
    waitFor("t5.pwndRise", 1, 1'b1, 60, tP);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1 checkOutput("t5.asyncRelease",
                   {camera_rstn_en, camera_pwnd_force, off_busy, power_off_done, iic_timeout},
                   5'b10000);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(0, 0, 0, 1, 30);
    checkOutput("t5.idleAfterReset", {camera_rstn_en, off_busy}, 2'b10);

    // Terminal OFF ignores every input for 100 cycles.
    applyStimulus(1, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 1, 0);
    waitFor("t6.doneRise", 3, 1'b1, 80, tD);
    for (int i = 0; i < 100; i++) begin
      applyStimulus(i[0], i[1], i[2], i[3], 1);
      checkOutput("t6.offHold",
                  {camera_rstn_en, camera_pwnd_force, off_busy, power_off_done, iic_timeout},
                  5'b01010);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/power_off_ctr.md
Name: power_off_ctr

Overview:
Orderly OV5640 power-down sequencer, the teardown counterpart of the power-on timing block.
- On request it waits for the IIC/SCCB engine to go idle and for a frame boundary.
- It then drives RSTB low, holds, drives PWDN high, holds, and reports the sensor off.
- Top level combines its outputs with the power-on block: camera_rstn = on_rstn & camera_rstn_en; camera_pwnd = on_pwnd | camera_pwnd_force.

Parameters:
Delay_IicTo, 240000, max cycles to wait for iic_busy low (10 ms at 24 MHz)
Delay_FrameTo, 2400000, max cycles to wait for a vsync rising edge (100 ms)
Delay_RstHold, 24000, cycles RSTB is held low before PWDN rises (1 ms)
Delay_PwdnHold, 24000, cycles PWDN is held high before done (1 ms)

Ports:
clk  in  1  24 MHz sensor-domain clock
rst  in  1  asynchronous, active-low reset
power_on_vd  in  1  high when the power-on sequence is complete
power_off_req  in  1  power-down request, pulse or level, clk domain
iic_busy  in  1  IIC/SCCB master busy, clk domain
cam_vsync  in  1  sensor VSYNC, asynchronous
camera_rstn_en  out  1  0 forces RSTB low
camera_pwnd_force  out  1  1 forces PWDN high
off_busy  out  1  sequence in progress
power_off_done  out  1  sensor powered down, level
iic_timeout  out  1  sticky: IIC idle wait timed out

Behaviour:
- Reset (rst=0, async): state IDLE; camera_rstn_en=1; camera_pwnd_force=0; off_busy=0; power_off_done=0; iic_timeout=0; timer=0; req latch=0; vsync synchronizer=0.
- All outputs are registered.
- cam_vsync passes through a 2-FF synchronizer plus an edge register. vs_rise is asserted 3 cycles after the input edge.
- power_off_req is latched (req_l) on any high cycle in IDLE or ACTIVE.
  - req_l clears on entry to WAIT_IIC.
  - A request seen in IDLE is honoured once ACTIVE is reached.
- Timer: 22-bit. Cleared on every state entry; increments each cycle in a timed state.
  - A hold of N means exactly N cycles in that state: exit when timer==N-1.
  - N=0 behaves as N=1.
- States:
  - IDLE: power_on_vd=1 -> ACTIVE.
  - ACTIVE: power_on_vd=0 -> IDLE. Else req_l=1 -> WAIT_IIC, off_busy=1.
  - WAIT_IIC: iic_busy=0 -> WAIT_VS. Else timer==Delay_IicTo-1 -> WAIT_VS with iic_timeout set (sticky until reset).
  - WAIT_VS: vs_rise -> RST_LOW. Else timer==Delay_FrameTo-1 -> RST_LOW.
  - RST_LOW: camera_rstn_en=0 on the first cycle in state. timer==Delay_RstHold-1 -> PWDN_HIGH.
  - PWDN_HIGH: camera_pwnd_force=1 on the first cycle in state; camera_rstn_en stays 0. timer==Delay_PwdnHold-1 -> OFF.
  - OFF: power_off_done=1, off_busy=0, forces held. Terminal until reset; power_off_req and power_on_vd are ignored.
- Once WAIT_IIC is entered, a power_on_vd drop is ignored; the sequence always completes.
- Simultaneous events:
  - iic_busy=0 on the timeout cycle: iic_timeout is NOT set.
  - vs_rise on the frame-timeout cycle: exit normally; no distinction is made.
- RSTB-low precedes PWDN-high by exactly Delay_RstHold cycles.
- Reset mid-sequence immediately releases both forces, because outputs revert asynchronously.

Test Plan:
1. Params 8/16/10/6. power_on_vd=1, iic_busy=0, pulse power_off_req, vsync edge 5 cycles later -> camera_rstn_en falls 4 cycles after the edge (sync plus transition). camera_pwnd_force rises 10 cycles later. power_off_done rises 6 cycles after that. iic_timeout=0.
2. iic_busy held high -> WAIT_IIC lasts exactly 8 cycles, then iic_timeout=1 and the sequence continues. A second run after reset with iic_busy falling at cycle 8 -> iic_timeout=0.
3. No vsync -> camera_rstn_en falls exactly 16 cycles after WAIT_VS entry.
4. power_off_req pulsed while power_on_vd=0, power_on_vd rising 20 cycles later -> sequence starts on ACTIVE entry. Separately, power_on_vd dropping during RST_LOW has no effect.
5. Assert rst during PWDN_HIGH -> camera_rstn_en=1 and camera_pwnd_force=0 combinationally, all flags 0. After release, back to IDLE.
6. In OFF, toggle power_off_req, iic_busy and vsync -> outputs unchanged for 100 cycles.
